// File: rtl/gpio_input_filt.sv
// Digital-input front end: per-channel synchronizer, optional debounce (GPIO_DEBOUNCE_EN),
// registered edge pulses and sticky interrupt-pending flags with a masked irq line.
module gpio_input_filt #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gpio_i,
   input  logic [CNT_W-1:0] db_limit,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic [WIDTH-1:0] irq_clr,
   output logic [WIDTH-1:0] di_status,
   output logic [WIDTH-1:0] di_rise,
   output logic [WIDTH-1:0] di_fall,
   output logic [WIDTH-1:0] irq_pending,
   output logic             irq
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] status_q, status_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] pend_q, pend_d;

   // Synchronizer chain; s is the metastability-safe sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Accept a new level once it has disagreed for db_limit+1 consecutive cycles;
   // the >= compare also covers db_limit being lowered under a running count.
   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (s[i] != status_q[i]) begin
            if (cnt_q[i] >= db_limit) accept[i] = 1'b1;
            else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`else
   logic unused_db_limit;
   assign unused_db_limit = ^db_limit;
   assign accept          = s ^ status_q;
`endif

   // Accepted transitions become edge pulses and feed the sticky pending flags
   always_comb begin
      status_d = (status_q & ~accept) | (s & accept);
      rise_d   = accept & s;
      fall_d   = accept & ~s;
      pend_d   = (pend_q & ~irq_clr) | (rise_d & rise_en) | (fall_d & fall_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         pend_q   <= '0;
      end else begin
         status_q <= status_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         pend_q   <= pend_d;
      end
   end

   assign di_status   = status_q;
   assign di_rise     = rise_q;
   assign di_fall     = fall_q;
   assign irq_pending = pend_q;
   assign irq         = |(pend_q & irq_mask);

endmodule

// File: tb/tb_gpio_input_filt.sv
// Bench for gpio_input_filt: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural model.
module tb_gpio_input_filt;
   localparam int unsigned W    = 32;
   localparam int unsigned SYNC = 2;
   localparam int unsigned CW   = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  gpio_i = '0, rise_en = '0, fall_en = '0, irq_mask = '0, irq_clr = '0;
   logic [CW-1:0] db_limit = '0;
   logic [W-1:0]  di_status, di_rise, di_fall, irq_pending;
   logic          irq;

   int n_cmp  = 0;
   int n_fail = 0;

   gpio_input_filt #(.WIDTH(W), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .gpio_i(gpio_i), .db_limit(db_limit),
      .rise_en(rise_en), .fall_en(fall_en), .irq_mask(irq_mask), .irq_clr(irq_clr),
      .di_status(di_status), .di_rise(di_rise), .di_fall(di_fall),
      .irq_pending(irq_pending), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Debounce threshold actually in force for this build
   function automatic int unsigned eff_lim();
`ifdef GPIO_DEBOUNCE_EN
      return int'(db_limit);
`else
      return 0;
`endif
   endfunction

   // Behavioural model: the level seen by the filter is the pin value captured SYNC edges
   // ago; a level is accepted after it has disagreed for eff_lim()+1 consecutive edges.
   logic [W-1:0] hist [$];
   logic [W-1:0] m_s = '0, m_status = '0, m_rise = '0, m_fall = '0, m_pend = '0;
   int unsigned  m_run [W];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
         m_status = '0; m_rise = '0; m_fall = '0; m_pend = '0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
         m_s = (hist.size() >= SYNC) ? hist[SYNC-1] : '0;
         hist.push_front(gpio_i);
         if (hist.size() > SYNC) void'(hist.pop_back());
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < W; i++) begin
            if (m_s[i] == m_status[i]) m_run[i] = 0;
            else if (m_run[i] >= eff_lim()) begin
               m_status[i] = m_s[i];
               m_run[i]    = 0;
               if (m_s[i]) m_rise[i] = 1'b1;
               else        m_fall[i] = 1'b1;
            end else m_run[i]++;
         end
         m_pend = (m_pend & ~irq_clr) | (m_rise & rise_en) | (m_fall & fall_en);
      end
   end

   // Per-cycle comparison, after the edge and after stimulus updates
   initial forever begin
      @(posedge clk);
      #2;
      chk("status", di_status, m_status);
      chk("rise", di_rise, m_rise);
      chk("fall", di_fall, m_fall);
      chk("pending", irq_pending, m_pend);
      chk("irq", 32'(irq), 32'(|(m_pend & irq_mask)));
      chk("rise_and_fall", di_rise & di_fall, 32'd0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat;
      logic        seen;

      // Reset state
      step(3);
      chk("rst_status", di_status, 32'd0);
      chk("rst_rise", di_rise, 32'd0);
      chk("rst_fall", di_fall, 32'd0);
      chk("rst_pending", irq_pending, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      step(2);

      // db_limit=0: bit 0 rise appears two edges after capture, one cycle wide
      gpio_i[0] = 1'b1;
      for (int n = 1; n <= int'(SYNC) + 2; n++) begin
         step(1);
         chk("lat_status0", 32'(di_status[0]), (n >= int'(SYNC) + 1) ? 32'd1 : 32'd0);
         chk("lat_rise0", 32'(di_rise[0]), (n == int'(SYNC) + 1) ? 32'd1 : 32'd0);
      end
      gpio_i[0] = 1'b0;
      step(6);

      // db_limit=4: four-sample glitch on bit 3, then a stable high
      db_limit = 16'd4;
      lat = SYNC + eff_lim();
      gpio_i[3] = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 16; n++) begin
         step(1);
         seen |= di_status[3];
         if (n == 3) gpio_i[3] = 1'b0;
      end
      chk("glitch3", 32'(seen), (eff_lim() >= 4) ? 32'd0 : 32'd1);
      gpio_i[3] = 1'b1;
      step(int'(lat));
      chk("db_before3", 32'(di_status[3]), 32'd0);
      step(1);
      chk("db_accept3", 32'(di_status[3]), 32'd1);
      chk("db_rise3", 32'(di_rise[3]), 32'd1);
      gpio_i[3] = 1'b0;
      step(int'(lat) + 3);
      db_limit = 16'd0;
      step(2);

      // Bit 5: rise-only enable, masked irq, clear, then fall must not set
      rise_en[5] = 1'b1; irq_mask[5] = 1'b1;
      gpio_i[5] = 1'b1;
      step(int'(SYNC) + 1);
      chk("pend5_rise", irq_pending, 32'h0000_0020);
      chk("irq5_rise", 32'(irq), 32'd1);
      irq_clr[5] = 1'b1;
      step(1);
      irq_clr[5] = 1'b0;
      chk("pend5_clr", irq_pending, 32'd0);
      chk("irq5_clr", 32'(irq), 32'd0);
      gpio_i[5] = 1'b0;
      step(int'(SYNC) + 3);
      chk("pend5_fall", irq_pending, 32'd0);

      // Bit 2: clear on the same edge as an accepted rise; set wins
      rise_en[2] = 1'b1;
      gpio_i[2] = 1'b1;
      step(int'(SYNC));
      irq_clr[2] = 1'b1;
      step(1);
      irq_clr[2] = 1'b0;
      chk("setwins_rise2", 32'(di_rise[2]), 32'd1);
      chk("setwins_pend2", irq_pending, 32'h0000_0004);

      // Masking hides irq without touching pending
      irq_mask = '0;
      #1;
      chk("mask_irq0", 32'(irq), 32'd0);
      step(3);
      chk("mask_pend", irq_pending, 32'h0000_0004);
      irq_mask = 32'h0000_0004;
      #1;
      chk("unmask_irq", 32'(irq), 32'd1);
      step(1);

      // Asynchronous reset mid-cycle with pending = 0xFF
      rise_en = 32'h0000_00FF;
      gpio_i  = 32'h0000_00FF;
      irq_mask = 32'h0000_00FF;
      step(int'(SYNC) + 2);
      chk("pend_ff", irq_pending, 32'h0000_00FF);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_status", di_status, 32'd0);
      chk("arst_rise", di_rise, 32'd0);
      chk("arst_pending", irq_pending, 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      step(2);
      rst_n = 1'b1;
      step(int'(SYNC) + 4);

      // Randomized phase; model checks every cycle
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            rise_en  = $urandom;
            fall_en  = $urandom;
            irq_mask = $urandom;
         end
         if (c % 300 == 0) db_limit = 16'($urandom_range(0, 6));
         gpio_i  = gpio_i ^ ($urandom & $urandom & $urandom & $urandom);
         irq_clr = $urandom & $urandom & $urandom;
         step(1);
      end
      irq_clr = '0;
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
